regfile_wport_arbiter: RTL and testbench

- Shares the single register-file write port (`we3`/`wa3`/`wd3`) between two writeback sources:
  - requester A, the ALU/execute path;
  - requester B, the load/multicycle path.
- Buffers each source in a small FIFO and picks one write per cycle, round-robin.
- Drops writes to x0 at enqueue.
- Exports a pending-write mask so issue logic can stall on registers with queued but uncommitted writes.
- Sits between the writeback stage and the 3-port register file; its outputs drive the register file write port directly.

---
 rtl/regfile_wport_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between an ALU (A) and a load/multicycle (B)
// writeback source: one FIFO per source, round-robin pick, x0 writes dropped at enqueue.
module regfile_wport_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        grant_b,
  output logic [31:0] pend_mask,
  output logic        conflict
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NREQ = 2;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  logic [NREQ-1:0]           in_valid_c;
  logic [NREQ-1:0][AW-1:0]   in_addr_c;
  logic [NREQ-1:0][DW-1:0]   in_data_c;
  logic [NREQ-1:0]           ready_c;
  logic [NREQ-1:0]           push_c;
  logic [NREQ-1:0]           pop_c;
  logic [NREQ-1:0]           nempty_c;
  logic [NREQ-1:0][AW-1:0]   head_addr_c;
  logic [NREQ-1:0][DW-1:0]   head_data_c;
  logic [NREQ-1:0][NREG-1:0] pend_c;
  logic                      grant_a_c;
  logic                      grant_b_c;
  logic                      last_winner_b_q;
  logic                      last_winner_b_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_valid_c  = {b_valid, a_valid};
  assign in_addr_c   = {b_addr, a_addr};
  assign in_data_c   = {b_data, a_data};
  assign a_ready     = ready_c[0];
  assign b_ready     = ready_c[1];

  // One circular FIFO per requester; a per-slot valid bit feeds the pending mask.
  for (genvar r = 0; r < NREQ; r++) begin : g_req
    logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;
    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]            count_q, count_d;

    assign ready_c[r]     = count_q < CW'(DEPTH);
    assign nempty_c[r]    = count_q != '0;
    assign push_c[r]      = in_valid_c[r] && ready_c[r] && (in_addr_c[r] != '0);
    assign head_addr_c[r] = addr_q[rd_ptr_q];
    assign head_data_c[r] = data_q[rd_ptr_q];

    always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      vld_d    = vld_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop_c[r]) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = ptr_inc(rd_ptr_q);
      end
      if (push_c[r]) begin
        addr_d[wr_ptr_q] = in_addr_c[r];
        data_d[wr_ptr_q] = in_data_c[r];
        vld_d[wr_ptr_q]  = 1'b1;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      unique case ({push_c[r], pop_c[r]})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        addr_q   <= '0;
        data_q   <= '0;
        vld_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        addr_q   <= addr_d;
        data_q   <= data_d;
        vld_q    <= vld_d;
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
      end
    end

    // Bit j is set when any stored slot targets register j.
    for (genvar j = 0; j < NREG; j++) begin : g_bit
      logic [DEPTH-1:0] hit;
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign hit[i] = vld_q[i] && (addr_q[i] == AW'(j));
      end
      assign pend_c[r][j] = |hit;
    end
  end

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_b_c       = nempty_c[1] && (!nempty_c[0] || !last_winner_b_q);
    grant_a_c       = nempty_c[0] && !grant_b_c;
    pop_c           = {grant_b_c, grant_a_c};
    last_winner_b_d = last_winner_b_q;
    if (grant_a_c || grant_b_c) begin
      last_winner_b_d = grant_b_c;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_winner_b_q <= 1'b1;
    end else begin
      last_winner_b_q <= last_winner_b_d;
    end
  end

  // Write port is driven straight from the winning FIFO head.
  always_comb begin
    we3     = grant_a_c || grant_b_c;
    wa3     = '0;
    wd3     = '0;
    grant_b = grant_b_c;
    if (grant_b_c) begin
      wa3 = head_addr_c[1];
      wd3 = head_data_c[1];
    end else if (grant_a_c) begin
      wa3 = head_addr_c[0];
      wd3 = head_data_c[0];
    end
    pend_mask = (pend_c[0] | pend_c[1]) & ~NREG'(1);
    conflict  = (&nempty_c) && (head_addr_c[0] == head_addr_c[1]) && (head_addr_c[0] != '0);
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: per-source expected-write queues
// checked against every committed write, plus cycle-exact port checks.
module tb_regfile_wport_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic        grant_b;
  logic [31:0] pend_mask;
  logic        conflict;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .grant_b(grant_b),
    .pend_mask(pend_mask), .conflict(conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic gb);
    chk({tag, "_we3"}, 32'(we3), 32'(we));
    chk({tag, "_wa3"}, 32'(wa3), 32'(wa));
    chk({tag, "_wd3"}, wd3, wd);
    chk({tag, "_grant_b"}, 32'(grant_b), 32'(gb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [4:0] ad, input logic [31:0] d);
    a_valid = 1'b1; a_addr = ad; a_data = d;
    if (ad != 5'd0) exp_a.push_back('{addr: ad, data: d});
  endtask

  task automatic send_b(input logic [4:0] ad, input logic [31:0] d);
    b_valid = 1'b1; b_addr = ad; b_data = d;
    if (ad != 5'd0) exp_b.push_back('{addr: ad, data: d});
  endtask

  task automatic idle_a();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
  endtask

  task automatic idle_b();
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // Scoreboard: every committed write must match the oldest expectation of its source.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && we3) begin
      checks++;
      if (grant_b) begin
        assert (exp_b.size() != 0) else begin
          errors++;
          $error("FAIL sb_b_unexpected: wa3=%0d wd3=0x%08h with nothing queued for B", wa3, wd3);
        end
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          chk("sb_b_addr", 32'(wa3), 32'(e.addr));
          chk("sb_b_data", wd3, e.data);
        end
      end else begin
        assert (exp_a.size() != 0) else begin
          errors++;
          $error("FAIL sb_a_unexpected: wa3=%0d wd3=0x%08h with nothing queued for A", wa3, wd3);
        end
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          chk("sb_a_addr", 32'(wa3), 32'(e.addr));
          chk("sb_a_data", wd3, e.data);
        end
      end
    end
  end

  initial begin
    idle_a();
    idle_b();
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk_out("rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    reset_n = 1'b1;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);

    // Single write from A
    send_a(5'd5, 32'hDEAD_BEEF);
    tick();
    idle_a();
    chk_out("single", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    chk("single_pend", pend_mask, 32'h0000_0020);
    tick();
    chk("single_done_we3", 32'(we3), 32'd0);
    chk("single_done_pend", pend_mask, 32'd0);

    // x0 write from B is a handshake but never stored
    chk("x0_b_ready_pre", 32'(b_ready), 32'd1);
    send_b(5'd0, 32'h0000_1234);
    tick();
    idle_b();
    chk("x0_we3", 32'(we3), 32'd0);
    chk("x0_pend", pend_mask, 32'd0);
    chk("x0_b_ready_post", 32'(b_ready), 32'd1);
    tick();
    chk("x0_we3_later", 32'(we3), 32'd0);

    // Backpressure on A with B kept busy; last winner is A here
    send_a(5'd11, 32'h111); send_b(5'd21, 32'h211);
    chk("bp0_a_ready", 32'(a_ready), 32'd1);
    tick();
    chk_out("bp1", 1'b1, 5'd21, 32'h211, 1'b1);
    chk("bp1_a_ready", 32'(a_ready), 32'd1);
    send_a(5'd12, 32'h112); send_b(5'd22, 32'h222);
    tick();
    chk_out("bp2", 1'b1, 5'd11, 32'h111, 1'b0);
    chk("bp2_a_ready_full", 32'(a_ready), 32'd0);
    chk("bp2_b_ready", 32'(b_ready), 32'd1);
    a_valid = 1'b1; a_addr = 5'd13; a_data = 32'h113;
    send_b(5'd23, 32'h223);
    tick();
    chk_out("bp3", 1'b1, 5'd22, 32'h222, 1'b1);
    chk("bp3_a_ready_after_pop", 32'(a_ready), 32'd1);
    chk("bp3_b_ready_full", 32'(b_ready), 32'd0);
    send_a(5'd13, 32'h113);
    idle_b();
    tick();
    idle_a();
    chk_out("bp4", 1'b1, 5'd12, 32'h112, 1'b0);
    chk("bp4_a_ready_full", 32'(a_ready), 32'd0);
    tick();
    chk_out("bp5", 1'b1, 5'd23, 32'h223, 1'b1);
    tick();
    chk_out("bp6", 1'b1, 5'd13, 32'h113, 1'b0);
    tick();
    chk("bp7_we3", 32'(we3), 32'd0);

    // Single write from B leaves B as last winner
    send_b(5'd9, 32'h99);
    tick();
    idle_b();
    chk_out("single_b", 1'b1, 5'd9, 32'h99, 1'b1);
    chk("single_b_pend", pend_mask, 32'h0000_0200);
    tick();
    chk("single_b_done", 32'(we3), 32'd0);

    // Round robin with both sides backlogged
    send_a(5'd1, 32'h11); send_b(5'd3, 32'h33);
    tick();
    chk_out("rr1", 1'b1, 5'd1, 32'h11, 1'b0);
    chk("rr1_pend", pend_mask, 32'h0000_000A);
    send_a(5'd2, 32'h22); send_b(5'd4, 32'h44);
    tick();
    idle_a(); idle_b();
    chk_out("rr2", 1'b1, 5'd3, 32'h33, 1'b1);
    chk("rr2_pend", pend_mask, 32'h0000_001C);
    tick();
    chk_out("rr3", 1'b1, 5'd2, 32'h22, 1'b0);
    chk("rr3_pend", pend_mask, 32'h0000_0014);
    tick();
    chk_out("rr4", 1'b1, 5'd4, 32'h44, 1'b1);
    chk("rr4_pend", pend_mask, 32'h0000_0010);
    tick();
    chk("rr5_we3", 32'(we3), 32'd0);
    chk("rr5_pend", pend_mask, 32'd0);
    chk("drain_a", 32'(exp_a.size()), 32'd0);
    chk("drain_b", 32'(exp_b.size()), 32'd0);

    // Conflict on r7, then asynchronous reset with entries still queued
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send_a(5'd7, 32'hA7); send_b(5'd7, 32'hB7);
    tick();
    chk_out("cf1", 1'b1, 5'd7, 32'hA7, 1'b0);
    chk("cf1_conflict", 32'(conflict), 32'd1);
    chk("cf1_pend", pend_mask, 32'h0000_0080);
    send_a(5'd7, 32'hA77);
    idle_b();
    tick();
    idle_a();
    chk_out("cf2", 1'b1, 5'd7, 32'hB7, 1'b1);
    chk("cf2_conflict", 32'(conflict), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    exp_a.delete();
    exp_b.delete();
    chk_out("arst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("arst_pend", pend_mask, 32'd0);
    chk("arst_conflict", 32'(conflict), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    chk("arst_a_ready", 32'(a_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we3", 32'(we3), 32'd0);
      chk("post_rst_pend", pend_mask, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
